// File: rtl/gpia_pkg.sv
// rtl/gpia_pkg.sv - shared mode encodings and register map for the GPIA Wishbone port
package gpia_pkg;

  localparam logic [1:0] GPIA_MODE_REPLACE = 2'b00;
  localparam logic [1:0] GPIA_MODE_SET     = 2'b01;
  localparam logic [1:0] GPIA_MODE_CLEAR   = 2'b10;
  localparam logic [1:0] GPIA_MODE_TOGGLE  = 2'b11;

  localparam logic [2:0] ADR_OUT_REPLACE = 3'd0;
  localparam logic [2:0] ADR_OUT_SET     = 3'd1;
  localparam logic [2:0] ADR_OUT_CLEAR   = 3'd2;
  localparam logic [2:0] ADR_OUT_TOGGLE  = 3'd3;
  localparam logic [2:0] ADR_IN          = 3'd4;
  localparam logic [2:0] ADR_EDGE        = 3'd5;
  localparam logic [2:0] ADR_IEN         = 3'd6;
  localparam logic [2:0] ADR_RSVD        = 3'd7;

  // The four output addresses share their low bits with the mode encoding.
  function automatic logic is_out_adr(input logic [2:0] adr);
    return ~adr[2];
  endfunction

endpackage

// File: rtl/gpia_sync_edge.sv
// rtl/gpia_sync_edge.sv - 8-bit multi-flop pin synchroniser with rising-edge detect
module gpia_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       res_i,
  input  logic [7:0] pins_i,
  output logic [7:0] sync_o,
  output logic [7:0] rise_o
);

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] hist_q;

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= pins_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~hist_q;

endmodule

// File: rtl/gpia_wb_port.sv
// rtl/gpia_wb_port.sv - Wishbone classic slave driving one GPIA output byte and edge-interrupt inputs
module gpia_wb_port
  import gpia_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       res_i,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [2:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic [1:0] gpia_mode_o,
  output logic [7:0] gpia_d_o,
  output logic       gpia_stb_o,
  input  logic [7:0] gpia_q_i,
  input  logic [7:0] pins_i,
  output logic       irq_o
);

  logic       req;
  logic       wr;
  logic [7:0] sync_pins;
  logic [7:0] rise;
  logic [7:0] status_q;
  logic [7:0] enable_q;
  logic [7:0] w1c_mask;
  logic [7:0] rd_data;

  gpia_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .res_i  (res_i),
    .pins_i (pins_i),
    .sync_o (sync_pins),
    .rise_o (rise)
  );

  // Gating on ~ack makes a held strobe complete one transfer every two cycles.
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr  = req & wb_we_i;

  always_comb begin
    rd_data = 8'h00;
    case (wb_adr_i)
      ADR_OUT_REPLACE, ADR_OUT_SET,
      ADR_OUT_CLEAR, ADR_OUT_TOGGLE: rd_data = gpia_q_i;
      ADR_IN:                        rd_data = sync_pins;
      ADR_EDGE:                      rd_data = status_q;
      ADR_IEN:                       rd_data = enable_q;
      default:                       rd_data = 8'h00;
    endcase
  end

  always_comb begin
    w1c_mask = 8'h00;
    if (wr && wb_adr_i == ADR_EDGE) w1c_mask = wb_dat_i;
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= 8'h00;
      gpia_mode_o <= GPIA_MODE_REPLACE;
      gpia_d_o    <= 8'h00;
      gpia_stb_o  <= 1'b0;
    end else begin
      wb_ack_o   <= req;
      wb_dat_o   <= (req && !wb_we_i) ? rd_data : 8'h00;
      gpia_stb_o <= wr && is_out_adr(wb_adr_i);
      if (wr && is_out_adr(wb_adr_i)) begin
        gpia_mode_o <= wb_adr_i[1:0];
        gpia_d_o    <= wb_dat_i;
      end
    end
  end

  // New edges are OR-ed in after the clear so a colliding edge survives.
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      status_q <= 8'h00;
      enable_q <= 8'h00;
      irq_o    <= 1'b0;
    end else begin
      status_q <= (status_q & ~w1c_mask) | rise;
      if (wr && wb_adr_i == ADR_IEN) enable_q <= wb_dat_i;
      irq_o <= |(status_q & enable_q);
    end
  end

endmodule

// File: doc/gpia_wb_port.md
Name: gpia_wb_port

Overview:
- Wishbone B3 classic slave front-end for one 8-bit GPIA port.
- Decodes bus writes into the mode/data/strobe triple consumed by the output byte stage downstream.
- Synchronises the 8 external input pins, latches rising edges, and raises a maskable interrupt.
- Sits between the system bus and the GPIA output byte; one instance per port.

Parameters:
SYNC_STAGES, 2, number of flops in each input-pin synchroniser (legal values 2..4).

Ports:
clk_i  in  1  system clock; all state changes on its rising edge
res_i  in  1  reset; asynchronous, active-high
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  bus strobe
wb_we_i  in  1  1 = write, 0 = read
wb_adr_i  in  3  register address
wb_dat_i  in  8  write data
wb_dat_o  out  8  read data; valid while wb_ack_o = 1
wb_ack_o  out  1  single-cycle acknowledge
gpia_mode_o  out  2  mode to output byte stage: 00 replace, 01 set, 10 clear, 11 toggle
gpia_d_o  out  8  data/mask to output byte stage
gpia_stb_o  out  1  one-cycle update strobe to output byte stage
gpia_q_i  in  8  current output byte value, used for readback
pins_i  in  8  asynchronous external input pins
irq_o  out  1  interrupt request, registered

Behaviour:
- Reset (asynchronous, res_i = 1): all outputs, synchroniser flops, edge-history flops, status register and enable register go to 0.
- Request condition: wb_cyc_i & wb_stb_i & ~wb_ack_o. On a clock edge with the request condition true, wb_ack_o = 1 for exactly the next cycle.
  - Fixed latency of 1 cycle.
  - No wait states and no error or retry.
  - A strobe held high therefore acks every second cycle. Each of those acks is a distinct transfer.
- Register map:
  - 0..3 W: on the request edge, drive gpia_mode_o = wb_adr_i[1:0], gpia_d_o = wb_dat_i, gpia_stb_o = 1. These are registered and coincide with wb_ack_o.
  - 0..3 R: returns gpia_q_i.
  - 4 R: returns the synchronised pins. Writes are ignored but still acked.
  - 5 R/W: edge-status. Read returns status. Write clears each bit written as 1 (W1C).
  - 6 R/W: interrupt-enable mask, plain register. Write loads wb_dat_i.
  - 7: reads 0x00; writes ignored but acked.
- gpia_stb_o is high only in the ack cycle of writes to addresses 0..3. gpia_mode_o and gpia_d_o hold their last value otherwise.
- wb_dat_o is registered with the ack and is 0x00 whenever wb_ack_o = 0.
- Synchroniser: SYNC_STAGES flops per pin, plus one history flop.
  - A rising edge in bit n is sync_out[n] & ~hist[n].
  - It sets status[n] on the following clock.
  - Pin-to-status latency = SYNC_STAGES + 1 cycles.
- Set wins: if an edge and a W1C write to the same bit occur on the same clock, the bit ends at 1.
- irq_o is registered: irq_o <= |(status & enable). It is one cycle behind the status/enable change.
- Writes with wb_cyc_i = 0, or wb_stb_i = 0, have no effect.
- Reset asserted mid-transfer: the ack is lost and the master must retry. gpia_stb_o is forced to 0 immediately.
- Pin glitches shorter than one clock are not guaranteed to be captured.

Decomposition:
- Shared package gpia_pkg:
  - mode encodings GPIA_MODE_REPLACE = 2'b00, GPIA_MODE_SET = 2'b01, GPIA_MODE_CLEAR = 2'b10, GPIA_MODE_TOGGLE = 2'b11.
  - register addresses ADR_OUT_* (0..3), ADR_IN = 4, ADR_EDGE = 5, ADR_IEN = 6.
- One sub-module, gpia_sync_edge: parameterised synchroniser plus rising-edge detector, 8 bits wide. It outputs sync_o[7:0] and rise_o[7:0].
- Bus decode, the status register and irq generation stay in the top level.

Test Plan:
1. Reset sequence:
   - Stimulus: res_i pulsed asynchronously mid-cycle.
   - Response: wb_ack_o, gpia_stb_o, irq_o and wb_dat_o are 0 immediately; reading address 5 and address 6 returns 0x00.
2. Write 0x0F to address 1:
   - Response: exactly one cycle later wb_ack_o = 1, gpia_stb_o = 1, gpia_mode_o = 01, gpia_d_o = 0x0F.
   - Next cycle: both wb_ack_o and gpia_stb_o are 0.
   - Holding stb for 4 cycles yields 2 acks and 2 strobes.
3. Read addresses:
   - pins_i = 0xA5, held ≥4 cycles, then read address 4 -> wb_dat_o = 0xA5 in the ack cycle.
   - gpia_q_i = 0x3C, read address 2 -> 0x3C.
   - Read address 7 -> 0x00.
4. Edge capture and interrupt:
   - Write 0x08 to address 6, then drive pins_i[3] 0->1.
   - Response: status = 0x08 exactly SYNC_STAGES + 1 cycles later; irq_o = 1 one cycle after that.
   - A falling edge on pins_i[3] sets no status bit.
5. W1C collision:
   - Write 0x08 to address 5 on the same clock a new edge on pins_i[3] reaches status -> status[3] stays 1 and irq_o stays 1.
   - A later write of 0x08 with no edge -> status = 0x00, and irq_o = 0 the following cycle.
6. Reset during a write request cycle:
   - Assert res_i in the cycle between the request edge and the expected ack.
   - Response: no ack, no gpia_stb_o; after release, a fresh write behaves as in test 2.
